hostaddr_table: RTL and testbench
=================================

HOSTADDR_TABLE -- requirements
Module: hostaddr_table

Interface
REQ-001 Parameter ADDR_WIDTH, default `HOST_ADDR_WIDTH, entry index width; DEPTH = 1 << ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default `VALUE_DATA_WIDTH + `VALUE_SIZE, entry width (value data plus size field).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 wr_en  in  1  write strobe.
REQ-006 wr_addr  in  ADDR_WIDTH  write index.
REQ-007 wr_data  in  DATA_WIDTH  write data.
REQ-008 inv_en  in  1  invalidate strobe; index taken from wr_addr.
REQ-009 clr_all  in  1  invalidate all entries.
REQ-010 rd_addr  in  ADDR_WIDTH  direct-read index, registered every cycle.
REQ-011 rd_data  out  DATA_WIDTH  array content at registered rd_addr.
REQ-012 rd_valid  out  1  valid bit of entry at registered rd_addr.
REQ-013 srch_req  in  1  search request; accepted only when srch_busy=0.
REQ-014 srch_key  in  DATA_WIDTH  search key; sampled on acceptance.
REQ-015 srch_busy  out  1  high in SCAN and DONE states.
REQ-016 srch_done  out  1  one-cycle pulse, result valid.
REQ-017 srch_hit  out  1  match found; held until next acceptance.
REQ-018 srch_idx  out  ADDR_WIDTH  lowest matching index; held with srch_hit.

Function
REQ-019 Array: DEPTH x DATA_WIDTH storage plus DEPTH valid bits; array data not reset, valid bits reset to 0.
REQ-020 Write: wr_en=1 stores wr_data at wr_addr and sets its valid bit at the edge.
REQ-021 Invalidate: inv_en=1 with wr_en=0 clears valid bit at wr_addr; wr_en=1 takes priority over inv_en.
REQ-022 clr_all=1 clears all valid bits at the edge; overrides any same-cycle wr_en/inv_en valid update (data still written).
REQ-023 Direct read: rd_addr registered each edge; rd_data/rd_valid driven combinationally from the registered index -> 1-cycle latency; same-cycle write to same index returns new data next cycle.
REQ-024 Search FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-025 IDLE: srch_req=1 -> latch srch_key, scan index=0, clear srch_hit, go SCAN; else stay.
REQ-026 SCAN: one entry per cycle; match = valid bit set AND entry data == latched key (full DATA_WIDTH compare).
REQ-027 SCAN match -> srch_hit=1, srch_idx=scan index, go DONE; no match at index DEPTH-1 -> srch_hit=0, go DONE; else index+1.
REQ-028 Latency: hit at index k -> srch_done high k+2 cycles after accept edge; miss -> DEPTH+1 cycles.
REQ-029 DONE: srch_done=1 for exactly one cycle, then IDLE; srch_req ignored in SCAN/DONE (no queuing).
REQ-030 Writes/invalidates during SCAN are permitted; compare uses array contents current in the compare cycle.
REQ-031 clr_all during SCAN aborts: next state DONE with srch_hit=0, srch_idx=0.
REQ-032 Scan index wraps never; width ADDR_WIDTH, terminates at DEPTH-1.

Reset
REQ-033 rst_n=0 at an edge: FSM to IDLE, all valid bits 0, registered rd_addr 0, srch_done=0, srch_hit=0, srch_idx=0, srch_busy=0.
REQ-034 Reset mid-search discards the search; no srch_done pulse produced.
REQ-035 After reset, rd_valid=0 for every index until written.

Verification
REQ-036 Reset, then rd_addr=3 -> rd_valid=0 next cycle; write 80'h6f726465726d61746368 at 2, rd_addr=2 -> rd_data equals it, rd_valid=1.
REQ-037 Write same key at 1 and 3, search key -> srch_done 3 cycles after accept, srch_hit=1, srch_idx=1.
REQ-038 Search key absent (DEPTH=4) -> srch_done 5 cycles after accept, srch_hit=0; srch_req held high during scan not re-accepted until IDLE.
REQ-039 Invalidate index 1 via inv_en, repeat REQ-037 search -> srch_idx=3; wr_en+inv_en same cycle -> entry valid.
REQ-040 clr_all asserted in SCAN -> srch_done next cycle with srch_hit=0; all rd_valid=0 afterwards.
REQ-041 rst_n=0 during SCAN -> no srch_done, srch_busy=0 next cycle, valid bits cleared.

Source files
------------

// File: rtl/hostaddr_table.sv
// Host address table: indexed storage with per-entry valid bits, direct read and linear key search.
// Latency: direct read 1 cycle; search hit at index k done k+2 cycles after accept, miss DEPTH+1.
// Backpressure: srch_busy high while a search runs; srch_req is ignored (not queued) until IDLE.

`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 2
`endif
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 72
`endif
`ifndef VALUE_SIZE
`define VALUE_SIZE 8
`endif

module hostaddr_table #(
   parameter int ADDR_WIDTH = `HOST_ADDR_WIDTH,
   parameter int DATA_WIDTH = `VALUE_DATA_WIDTH + `VALUE_SIZE
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  inv_en,
   input  logic                  clr_all,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  srch_req,
   input  logic [DATA_WIDTH-1:0] srch_key,
   output logic                  srch_busy,
   output logic                  srch_done,
   output logic                  srch_hit,
   output logic [ADDR_WIDTH-1:0] srch_idx
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      vld;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [ADDR_WIDTH-1:0] scan_idx;
   logic [DATA_WIDTH-1:0] key_q;
   logic [1:0]            state;
   logic                  hit_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic                  match;

   // Entry data: plain storage, never reset; clr_all does not block the data write.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Valid bits: clr_all beats write, write beats invalidate.
   always_ff @(posedge clk) begin
      if (!rst_n)       vld <= '0;
      else if (clr_all) vld <= '0;
      else if (wr_en)   vld[wr_addr] <= 1'b1;
      else if (inv_en)  vld[wr_addr] <= 1'b0;
   end

   // Read index register; data/valid are looked up combinationally behind it.
   always_ff @(posedge clk) begin
      if (!rst_n) rd_addr_q <= '0;
      else        rd_addr_q <= rd_addr;
   end

   assign rd_data  = mem[rd_addr_q];
   assign rd_valid = vld[rd_addr_q];

   // Compare against the array as it stands this cycle, so in-flight writes are seen.
   assign match = vld[scan_idx] && (mem[scan_idx] == key_q);

   // Search key capture on acceptance only.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && srch_req) key_q <= srch_key;
   end

   // Search FSM: one entry per cycle from index 0, stop at first hit, abort on clr_all.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         scan_idx <= '0;
         hit_q    <= 1'b0;
         idx_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (srch_req) begin
                  scan_idx <= '0;
                  hit_q    <= 1'b0;
                  state    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (clr_all) begin
                  hit_q <= 1'b0;
                  idx_q <= '0;
                  state <= ST_DONE;
               end else if (match) begin
                  hit_q <= 1'b1;
                  idx_q <= scan_idx;
                  state <= ST_DONE;
               end else if (scan_idx == LAST_IDX) begin
                  hit_q <= 1'b0;
                  state <= ST_DONE;
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign srch_busy = (state == ST_SCAN) || (state == ST_DONE);
   assign srch_done = (state == ST_DONE);
   assign srch_hit  = hit_q;
   assign srch_idx  = idx_q;

endmodule

// File: tb/tb_hostaddr_table.sv
// Directed bench for hostaddr_table (DEPTH=4, 80-bit entries).
// Table-driven write/invalidate/read vectors plus hand-written search sequences.
// Outputs are sampled on the falling clock edge.

module tb_hostaddr_table;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, inv_en, clr_all;
   logic [1:0]  wr_addr, rd_addr;
   logic [79:0] wr_data, srch_key;
   logic [79:0] rd_data;
   logic        rd_valid;
   logic        srch_req, srch_busy, srch_done, srch_hit;
   logic [1:0]  srch_idx;

   int checks   = 0;
   int failures = 0;

   localparam logic [79:0] K = 80'h6f726465726d61746368;
   localparam logic [79:0] B = 80'h0123456789abcdef0011;
   localparam logic [79:0] C = 80'h6f726465726d61746369;
   localparam logic [79:0] D = 80'hdeadbeefcafef00d5555;

   hostaddr_table #(.ADDR_WIDTH(2), .DATA_WIDTH(80)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .inv_en(inv_en), .clr_all(clr_all),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .srch_req(srch_req), .srch_key(srch_key),
      .srch_busy(srch_busy), .srch_done(srch_done),
      .srch_hit(srch_hit), .srch_idx(srch_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        inv;
      logic [1:0]  wa;
      logic [79:0] wd;
      logic [1:0]  ra;
      logic        ev;
      logic [79:0] ed;
      logic        cd;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock with the given controls; returns at the following falling edge.
   task automatic cyc(input logic w, input logic i, input logic c,
                      input logic [1:0] a, input logic [79:0] d, input logic [1:0] ra);
      wr_en = w; inv_en = i; clr_all = c; wr_addr = a; wr_data = d; rd_addr = ra;
      @(posedge clk);
      #1;
      wr_en = 1'b0; inv_en = 1'b0; clr_all = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int v = lo; v <= hi; v++) begin
         cyc(vecs[v].wr, vecs[v].inv, 1'b0, vecs[v].wa, vecs[v].wd, vecs[v].ra);
         chk($sformatf("vec%0d rd_valid", v), {79'd0, rd_valid}, {79'd0, vecs[v].ev});
         if (vecs[v].cd) chk($sformatf("vec%0d rd_data", v), rd_data, vecs[v].ed);
      end
   endtask

   // Accept a search, count falling edges until srch_done, then check result and idle.
   task automatic search(input string nm, input logic [79:0] key, input logic exp_hit,
                         input logic [1:0] exp_idx, input int exp_lat, input logic hold);
      int lat = 0;
      srch_req = 1'b1;
      srch_key = key;
      @(posedge clk);
      #1;
      if (!hold) srch_req = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (srch_done) begin
            lat = n;
            break;
         end
         if (!srch_busy) break;
      end
      srch_req = 1'b0;
      chk({nm, " latency"}, 80'(lat), 80'(exp_lat));
      chk({nm, " hit"}, {79'd0, srch_hit}, {79'd0, exp_hit});
      if (exp_hit) chk({nm, " idx"}, {78'd0, srch_idx}, {78'd0, exp_idx});
      @(negedge clk);
      chk({nm, " busy after"}, {79'd0, srch_busy}, 80'd0);
      chk({nm, " hit held"}, {79'd0, srch_hit}, {79'd0, exp_hit});
   endtask

   initial begin
      //            wr    inv   wa    wd  ra    ev    ed  cd
      vecs[0]  = '{1'b0, 1'b0, 2'd0, '0, 2'd3, 1'b0, '0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 2'd2, K,  2'd2, 1'b1, K,  1'b1};
      vecs[2]  = '{1'b1, 1'b0, 2'd2, C,  2'd2, 1'b1, C,  1'b1};
      vecs[3]  = '{1'b1, 1'b0, 2'd1, K,  2'd1, 1'b1, K,  1'b1};
      vecs[4]  = '{1'b1, 1'b0, 2'd3, K,  2'd3, 1'b1, K,  1'b1};
      vecs[5]  = '{1'b1, 1'b0, 2'd0, B,  2'd0, 1'b1, B,  1'b1};
      vecs[6]  = '{1'b0, 1'b0, 2'd0, '0, 2'd2, 1'b1, C,  1'b1};
      vecs[7]  = '{1'b0, 1'b1, 2'd1, '0, 2'd1, 1'b0, '0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 2'd0, '0, 2'd3, 1'b1, K,  1'b1};
      vecs[9]  = '{1'b1, 1'b1, 2'd1, K,  2'd1, 1'b1, K,  1'b1};
      vecs[10] = '{1'b0, 1'b0, 2'd0, '0, 2'd1, 1'b1, K,  1'b1};

      rst_n = 1'b0; wr_en = 1'b0; inv_en = 1'b0; clr_all = 1'b0;
      wr_addr = '0; wr_data = '0; rd_addr = '0; srch_req = 1'b0; srch_key = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", {79'd0, srch_busy}, 80'd0);
      chk("reset done", {79'd0, srch_done}, 80'd0);
      chk("reset hit",  {79'd0, srch_hit},  80'd0);
      chk("reset idx",  {78'd0, srch_idx},  80'd0);
      chk("reset rd_valid", {79'd0, rd_valid}, 80'd0);
      rst_n = 1'b1;

      // Basic writes and reads, entry 2 overwritten so K lives only at 1 and 3.
      run_vecs(0, 6);
      search("hit1", K, 1'b1, 2'd1, 3, 1'b0);
      search("miss", D, 1'b0, 2'd0, 5, 1'b1);

      // Invalidate entry 1, the lowest match moves to 3.
      run_vecs(7, 8);
      search("hit3", K, 1'b1, 2'd3, 5, 1'b0);

      // Write wins over invalidate in the same cycle.
      run_vecs(9, 10);
      search("hit1 again", K, 1'b1, 2'd1, 3, 1'b0);

      // clr_all during SCAN aborts with no hit, then every entry reads invalid.
      srch_req = 1'b1; srch_key = K;
      @(posedge clk);
      #1 srch_req = 1'b0;
      @(negedge clk);
      chk("abort busy in scan", {79'd0, srch_busy}, 80'd1);
      clr_all = 1'b1;
      @(posedge clk);
      #1 clr_all = 1'b0;
      @(negedge clk);
      chk("abort done", {79'd0, srch_done}, 80'd1);
      chk("abort hit",  {79'd0, srch_hit},  80'd0);
      chk("abort idx",  {78'd0, srch_idx},  80'd0);
      for (int a = 0; a < 4; a++) begin
         cyc(1'b0, 1'b0, 1'b0, 2'd0, '0, 2'(a));
         chk($sformatf("cleared rd_valid[%0d]", a), {79'd0, rd_valid}, 80'd0);
      end

      // Reset during SCAN: search discarded, no done pulse, valid bits gone.
      cyc(1'b1, 1'b0, 1'b0, 2'd3, K, 2'd3);
      chk("rewrite 3 valid", {79'd0, rd_valid}, 80'd1);
      srch_req = 1'b1; srch_key = K;
      @(posedge clk);
      #1 srch_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst scan busy", {79'd0, srch_busy}, 80'd0);
      chk("rst scan done", {79'd0, srch_done}, 80'd0);
      chk("rst scan rd_valid", {79'd0, rd_valid}, 80'd0);
      begin
         int seen = 0;
         for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (srch_done) seen++;
         end
         chk("rst scan no done", 80'(seen), 80'd0);
      end
      cyc(1'b0, 1'b0, 1'b0, 2'd0, '0, 2'd3);
      chk("rst entry3 invalid", {79'd0, rd_valid}, 80'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
